// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and registers the returned word into IF/ID, with a sticky fetch fault.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
  typedef enum logic [1:0] {ACT_FETCH, ACT_HOLD, ACT_REDIRECT, ACT_FAULT} act_t;

  // First byte address past the end of instruction memory.
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS) * 32'd4;

  state_t state, state_nxt;
  act_t   act;

  // The PC is kept as a word index so its two low bits cannot be anything but zero.
  logic [29:0] pc_word_p0;
  logic [31:0] pc_p0;
  logic [31:0] pc4_p0;

  logic [31:0] instr_p1;
  logic [31:0] pc4_p1;
  logic        vld_p1;
  logic [31:0] count;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  assign pc_p0  = {pc_word_p0, 2'b00};
  assign pc4_p0 = pc_p0 + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    act       = ACT_HOLD;
    case (state)
      RUN: begin
        if (redirect_valid && misaligned(redirect_target)) begin
          act       = ACT_FAULT;
          state_nxt = HALT;
        end else if (redirect_valid) begin
          act = ACT_REDIRECT;
        end else if (pc_p0 >= PC_LIMIT) begin
          act       = ACT_FAULT;
          state_nxt = HALT;
        end else if (stall) begin
          act = ACT_HOLD;
        end else begin
          act = ACT_FETCH;
        end
      end
      default: begin
        act       = ACT_HOLD;
        state_nxt = HALT;
      end
    endcase
  end

  always_comb begin
    fault = (state == HALT);
  end

  // Stage 0 -> 1: PC update and IF/ID capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_word_p0 <= RESET_PC[31:2];
      instr_p1   <= 32'h0;
      pc4_p1     <= 32'h0;
      vld_p1     <= 1'b0;
      count      <= 32'h0;
    end else begin
      case (act)
        ACT_FETCH: begin
          instr_p1   <= imem_instr;
          pc4_p1     <= pc4_p0;
          vld_p1     <= 1'b1;
          pc_word_p0 <= pc4_p0[31:2];
          count      <= count + 32'd1;
        end
        ACT_REDIRECT: begin
          pc_word_p0 <= redirect_target[31:2];
          instr_p1   <= 32'h0;
          pc4_p1     <= 32'h0;
          vld_p1     <= 1'b0;
        end
        ACT_FAULT: begin
          instr_p1 <= 32'h0;
          pc4_p1   <= 32'h0;
          vld_p1   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_addr   = pc_p0;
  assign if_id_instr = instr_p1;
  assign if_id_pc4   = pc4_p1;
  assign if_id_valid = vld_p1;
  assign fetch_count = count;

  a_halt_no_valid: assert property (@(posedge clk) disable iff (reset) fault |-> !if_id_valid);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed table-driven bench for instr_fetch with a small behavioural instruction memory.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[7:2]];

  instr_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(64)) dut (
    .clk(clk),
    .reset(reset),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid),
    .fault(fault),
    .fetch_count(fetch_count)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        v;
    logic        f;
    logic [31:0] pc;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] m(input int i);
    case (i)
      0: return 32'h20080020;
      1: return 32'h20090037;
      2: return 32'h01098020;
      3: return 32'h01098822;
      default: return 32'h1000_0000 | 32'(i);
    endcase
  endfunction

  task automatic add(input logic rst, input logic stl, input logic rv, input logic [31:0] tgt,
                     input logic [31:0] instr, input logic [31:0] pc4, input logic v,
                     input logic f, input logic [31:0] pc, input logic [31:0] cnt);
    vec_t e;
    e.rst = rst; e.stl = stl; e.rv = rv; e.tgt = tgt;
    e.instr = instr; e.pc4 = pc4; e.v = v; e.f = f; e.pc = pc; e.cnt = cnt;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic stl, input logic rv, input logic [31:0] tgt);
    reset = rst; stall = stl; redirect_valid = rv; redirect_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                         input logic v, input logic f, input logic [31:0] pc, input logic [31:0] cnt);
    chk({tag, ".instr"}, if_id_instr, instr);
    chk({tag, ".pc4"},   if_id_pc4,   pc4);
    chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, v});
    chk({tag, ".fault"}, {31'h0, fault},       {31'h0, f});
    chk({tag, ".pc"},    imem_addr,   pc);
    chk({tag, ".count"}, fetch_count, cnt);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = m(i);

    //   rst stl rv  tgt        instr     pc4        v  f  pc         cnt
    add(1, 0, 0, 32'h0,  32'h0, 32'h0,  0, 0, 32'h0,  0);   // reset
    add(0, 0, 0, 32'h0,  m(0),  32'h4,  1, 0, 32'h4,  1);
    add(0, 0, 0, 32'h0,  m(1),  32'h8,  1, 0, 32'h8,  2);
    add(0, 0, 0, 32'h0,  m(2),  32'hC,  1, 0, 32'hC,  3);
    add(0, 1, 0, 32'h0,  m(2),  32'hC,  1, 0, 32'hC,  3);   // stall x3
    add(0, 1, 0, 32'h0,  m(2),  32'hC,  1, 0, 32'hC,  3);
    add(0, 1, 0, 32'h0,  m(2),  32'hC,  1, 0, 32'hC,  3);
    add(0, 0, 0, 32'h0,  m(3),  32'h10, 1, 0, 32'h10, 4);
    add(0, 0, 0, 32'h0,  m(4),  32'h14, 1, 0, 32'h14, 5);
    add(0, 0, 0, 32'h0,  m(5),  32'h18, 1, 0, 32'h18, 6);
    add(0, 0, 0, 32'h0,  m(6),  32'h1C, 1, 0, 32'h1C, 7);
    add(0, 0, 0, 32'h0,  m(7),  32'h20, 1, 0, 32'h20, 8);
    add(0, 0, 1, 32'h18, 32'h0, 32'h0,  0, 0, 32'h18, 8);   // redirect back to 0x18
    add(0, 0, 0, 32'h0,  m(6),  32'h1C, 1, 0, 32'h1C, 9);
    add(0, 1, 1, 32'h0,  32'h0, 32'h0,  0, 0, 32'h0,  9);   // redirect beats stall
    add(0, 1, 0, 32'h0,  32'h0, 32'h0,  0, 0, 32'h0,  9);   // stall keeps bubble
    add(0, 0, 0, 32'h0,  m(0),  32'h4,  1, 0, 32'h4,  10);
    add(0, 0, 1, 32'h1A, 32'h0, 32'h0,  0, 1, 32'h4,  10);  // misaligned -> halt
    add(0, 0, 0, 32'h0,  32'h0, 32'h0,  0, 1, 32'h4,  10);
    add(0, 0, 1, 32'h8,  32'h0, 32'h0,  0, 1, 32'h4,  10);  // halt ignores redirect
    add(1, 0, 0, 32'h0,  32'h0, 32'h0,  0, 0, 32'h0,  0);   // reset clears fault
    add(0, 0, 0, 32'h0,  m(0),  32'h4,  1, 0, 32'h4,  1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].stl, vecs[i].rv, vecs[i].tgt);
      chk_all($sformatf("vec%0d", i), vecs[i].instr, vecs[i].pc4, vecs[i].v,
              vecs[i].f, vecs[i].pc, vecs[i].cnt);
    end

    // Free-run to the end of memory; the fetch at 0x100 must fault.
    for (int i = 0; i < 200 && imem_addr != 32'h100; i++) step(0, 0, 0, 32'h0);
    chk_all("end_of_mem", m(63), 32'h100, 1, 0, 32'h100, 64);
    step(0, 0, 0, 32'h0);
    chk_all("range_fault", 32'h0, 32'h0, 0, 1, 32'h100, 64);

    // Aligned out-of-range redirect is accepted; range fault fires next edge even under stall.
    step(1, 0, 0, 32'h0);
    chk_all("reset2", 32'h0, 32'h0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h200);
    chk_all("oor_redirect", 32'h0, 32'h0, 0, 0, 32'h200, 1);
    step(0, 1, 0, 32'h0);
    chk_all("oor_fault_stall", 32'h0, 32'h0, 0, 1, 32'h200, 1);

    // Reset in the middle of a run.
    step(1, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    chk_all("mid_reset", 32'h0, 32'h0, 0, 0, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
